// File: rtl/pad_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pad_cfg_sequencer
// Holds one config word per user pad and serially loads the pad control chain.
// Optional : PAD_CFG_READBACK_EN adds a chain readback check (rb_err output).
// Revision : 1.0 - initial release
// ============================================================================
module pad_cfg_sequencer #(
   parameter int N_PADS   = 38,
   parameter int CFG_BITS = 13,
   parameter int CLK_DIV  = 1,
   parameter int AW       = $clog2(N_PADS)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                cfg_we,
   input  logic [AW-1:0]       cfg_addr,
   input  logic [CFG_BITS-1:0] cfg_wdata,
   output logic [CFG_BITS-1:0] cfg_rdata,
   input  logic                load_req,
   output logic                busy,
   output logic                done,
   output logic                wr_err,
   output logic                serial_data_out,
   output logic                serial_clock,
   output logic                serial_load,
`ifdef PAD_CFG_READBACK_EN
   output logic                rb_err,
`endif
   input  logic                serial_data_in
);
   localparam int c_tot = N_PADS * CFG_BITS;
   localparam int c_bw  = $clog2(c_tot + 1);
   localparam int c_dw  = $clog2(CLK_DIV + 1);
   localparam logic [AW:0]      c_n_pads   = (AW+1)'(N_PADS);
   localparam logic [c_bw-1:0]  c_tot_cnt  = c_bw'(c_tot);
   localparam logic [c_dw-1:0]  c_div_last = c_dw'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SHIFT_LO = 3'd1,
      ST_SHIFT_HI = 3'd2,
      ST_LOAD     = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [CFG_BITS-1:0]   r_cfg [N_PADS];
   logic [c_tot-1:0]      r_shift, w_shift_nxt, w_snap;
   logic [c_bw-1:0]       r_bit_cnt;
   logic [c_dw-1:0]       r_div;
   logic                  r_sdo, r_wr_err;
   logic                  w_addr_ok, w_wr_ok, w_wr_rej, w_phase_end, w_last_bit, w_start;

   assign w_addr_ok   = ({1'b0, cfg_addr} < c_n_pads);
   assign w_wr_ok     = cfg_we && (r_state == ST_IDLE) && w_addr_ok;
   assign w_wr_rej    = cfg_we && !w_wr_ok;
   assign w_phase_end = (r_div == c_div_last);
   assign w_last_bit  = ((r_bit_cnt + c_bw'(1)) == c_tot_cnt);
   assign w_start     = (r_state == ST_IDLE) && load_req;
   assign w_shift_nxt = r_shift << 1;

   assign serial_data_out = r_sdo;
   assign wr_err          = r_wr_err;

   always_comb begin
      cfg_rdata = '0;
      for (int i = 0; i < N_PADS; i++)
         if (cfg_addr == AW'(i)) cfg_rdata = r_cfg[i];
   end

   // Pad N_PADS-1 occupies the top of the stream so it leaves first, MSB first.
   always_comb begin
      w_snap = '0;
      for (int i = 0; i < N_PADS; i++) w_snap[i*CFG_BITS +: CFG_BITS] = r_cfg[i];
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      serial_clock = 1'b0;
      serial_load  = 1'b0;
      case (r_state)
         ST_IDLE:     if (load_req) w_state_nxt = ST_SHIFT_LO;
         ST_SHIFT_LO: begin
            busy = 1'b1;
            if (w_phase_end) w_state_nxt = ST_SHIFT_HI;
         end
         ST_SHIFT_HI: begin
            busy         = 1'b1;
            serial_clock = 1'b1;
            if (w_phase_end) w_state_nxt = w_last_bit ? ST_LOAD : ST_SHIFT_LO;
         end
         ST_LOAD: begin
            busy        = 1'b1;
            serial_load = 1'b1;
            if (w_phase_end) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_div     <= '0;
         r_sdo     <= 1'b0;
         r_wr_err  <= 1'b0;
         for (int i = 0; i < N_PADS; i++) r_cfg[i] <= '0;
      end else begin
         if (w_wr_ok)
            for (int i = 0; i < N_PADS; i++)
               if (cfg_addr == AW'(i)) r_cfg[i] <= cfg_wdata;
         // A rejected write in the same cycle as load_req must not be lost.
         if (w_wr_rej)      r_wr_err <= 1'b1;
         else if (load_req) r_wr_err <= 1'b0;

         if (r_state == ST_IDLE || w_state_nxt != r_state) r_div <= '0;
         else                                              r_div <= r_div + c_dw'(1);

         if (w_start) begin
            r_shift   <= w_snap;
            r_sdo     <= w_snap[c_tot-1];
            r_bit_cnt <= '0;
         end else if (r_state == ST_SHIFT_HI && w_phase_end) begin
            r_bit_cnt <= r_bit_cnt + c_bw'(1);
            if (!w_last_bit) begin
               r_shift <= w_shift_nxt;
               r_sdo   <= w_shift_nxt[c_tot-1];
            end
         end
      end
   end

`ifdef PAD_CFG_READBACK_EN
   logic [c_tot-1:0] r_cap, r_tx, r_prev, w_rb_exp;
   logic             r_rb_err;

   // The chain output already shows the previous stream's first bit before any
   // clock, so after TOT rising edges the samples are prev bits 1..TOT-1 plus
   // the first bit of the current stream.
   assign w_rb_exp = (r_prev << 1) | c_tot'(r_tx[c_tot-1]);
   assign rb_err   = r_rb_err;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cap    <= '0;
         r_tx     <= '0;
         r_prev   <= '0;
         r_rb_err <= 1'b0;
      end else begin
         if (w_start) r_tx <= w_snap;
         if (r_state == ST_SHIFT_HI && w_phase_end)
            r_cap <= (r_cap << 1) | c_tot'(serial_data_in);
         if (r_state == ST_LOAD && w_phase_end) begin
            r_prev <= r_tx;
            if (r_cap != w_rb_exp) r_rb_err <= 1'b1;
         end else if (load_req) begin
            r_rb_err <= 1'b0;
         end
      end
   end
`else
   logic w_unused;
   assign w_unused = serial_data_in;
`endif

endmodule
`default_nettype wire
